// File: rtl/smi_frame_pkg.sv
// Shared frame-type constants, FSM state types and the final-flit test for the
// SMI frame routing blocks.
package smi_frame_pkg;

  localparam logic [7:0] ReadReqType   = 8'h01;
  localparam logic [7:0] WriteReqType  = 8'h02;
  localparam logic [7:0] ReadRespType  = 8'hFD;
  localparam logic [7:0] WriteRespType = 8'hFE;

  typedef enum logic [1:0] {ReqIdle, FwdWrite, FwdRead, Drop} reqState_t;
  typedef enum logic [1:0] {RespIdle, GrantWrite, GrantRead} respState_t;

  // Any non-zero eofc marks the last flit and carries its valid byte count.
  function automatic logic isFinalFlit(input logic [7:0] eofc);
    return eofc != 8'd0;
  endfunction

endpackage

// File: rtl/smi_frame_buffer.sv
// One-flit registered ready/stop stage; accepts a new flit every cycle unless
// the held flit is being stalled by the downstream side.
module smi_frame_buffer #(
  parameter int DataWidth = 128
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 upReady,
  input  logic [7:0]           upEofc,
  input  logic [DataWidth-1:0] upData,
  output logic                 upStop,
  output logic                 downReady,
  output logic [7:0]           downEofc,
  output logic [DataWidth-1:0] downData,
  input  logic                 downStop
);

  assign upStop = srst | (downReady & downStop);

  always_ff @(posedge clk) begin
    if (srst) begin
      downReady <= 1'b0;
    end else if (!upStop) begin
      downReady <= upReady;
    end
  end

  always_ff @(posedge clk) begin
    if (upReady && !upStop) begin
      downEofc <= upEofc;
      downData <= upData;
    end
  end

endmodule

// File: rtl/smi_frame_type_router.sv
// Routes request frames to write/read paths by their first-flit type byte and
// merges write/read response frames with a frame-atomic round-robin arbiter.
module smi_frame_type_router
  import smi_frame_pkg::*;
#(
  parameter int         DataIndexSize = 4,
  parameter int         DataWidth     = (1 << DataIndexSize) * 8,
  parameter logic [7:0] ReadReqId     = ReadReqType,
  parameter logic [7:0] WriteReqId    = WriteReqType
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 smiReqReady,
  input  logic [7:0]           smiReqEofc,
  input  logic [DataWidth-1:0] smiReqData,
  output logic                 smiReqStop,
  output logic                 smiWrReqReady,
  output logic [7:0]           smiWrReqEofc,
  output logic [DataWidth-1:0] smiWrReqData,
  input  logic                 smiWrReqStop,
  output logic                 smiRdReqReady,
  output logic [7:0]           smiRdReqEofc,
  output logic [DataWidth-1:0] smiRdReqData,
  input  logic                 smiRdReqStop,
  input  logic                 smiWrRespReady,
  input  logic [7:0]           smiWrRespEofc,
  input  logic [DataWidth-1:0] smiWrRespData,
  output logic                 smiWrRespStop,
  input  logic                 smiRdRespReady,
  input  logic [7:0]           smiRdRespEofc,
  input  logic [DataWidth-1:0] smiRdRespData,
  output logic                 smiRdRespStop,
  output logic                 smiRespReady,
  output logic [7:0]           smiRespEofc,
  output logic [DataWidth-1:0] smiRespData,
  input  logic                 smiRespStop,
  output logic                 dropError
);

  reqState_t  reqState;
  respState_t respState;
  logic       preferWrite;
  logic       selWrite, selRead, reqXfer, wrBufStop, rdBufStop;
  logic       grantWr, grantRd, respBufStop, respXfer, mergedReady;
  logic [7:0] mergedEofc;
  logic [DataWidth-1:0] mergedData;

  // In idle the presented flit is decoded directly so it routes with no extra cycle.
  always_comb begin
    selWrite = 1'b0;
    selRead  = 1'b0;
    case (reqState)
      ReqIdle: begin
        selWrite = (smiReqData[7:0] == WriteReqId);
        selRead  = (smiReqData[7:0] == ReadReqId);
      end
      FwdWrite: selWrite = 1'b1;
      FwdRead:  selRead  = 1'b1;
      default:  ;
    endcase
  end

  assign smiReqStop = selWrite ? wrBufStop : (selRead ? rdBufStop : srst);
  assign reqXfer    = smiReqReady & ~smiReqStop;

  always_ff @(posedge clk) begin
    if (srst) begin
      reqState  <= ReqIdle;
      dropError <= 1'b0;
    end else if (reqXfer) begin
      if (reqState == ReqIdle) begin
        if (!selWrite && !selRead) dropError <= 1'b1;
        if (!isFinalFlit(smiReqEofc)) begin
          if (selWrite)     reqState <= FwdWrite;
          else if (selRead) reqState <= FwdRead;
          else              reqState <= Drop;
        end
      end else if (isFinalFlit(smiReqEofc)) begin
        reqState <= ReqIdle;
      end
    end
  end

  smi_frame_buffer #(.DataWidth(DataWidth)) wrReqBuf (
    .clk(clk), .srst(srst),
    .upReady(smiReqReady & selWrite), .upEofc(smiReqEofc), .upData(smiReqData), .upStop(wrBufStop),
    .downReady(smiWrReqReady), .downEofc(smiWrReqEofc), .downData(smiWrReqData), .downStop(smiWrReqStop)
  );

  smi_frame_buffer #(.DataWidth(DataWidth)) rdReqBuf (
    .clk(clk), .srst(srst),
    .upReady(smiReqReady & selRead), .upEofc(smiReqEofc), .upData(smiReqData), .upStop(rdBufStop),
    .downReady(smiRdReqReady), .downEofc(smiRdReqEofc), .downData(smiRdReqData), .downStop(smiRdReqStop)
  );

  // A tie in idle goes to the side not granted last; a grant then spans the frame.
  always_comb begin
    grantWr = 1'b0;
    grantRd = 1'b0;
    case (respState)
      RespIdle: begin
        grantWr = smiWrRespReady & (~smiRdRespReady | preferWrite);
        grantRd = smiRdRespReady & ~grantWr;
      end
      GrantWrite: grantWr = 1'b1;
      GrantRead:  grantRd = 1'b1;
      default:    ;
    endcase
  end

  assign mergedReady   = (grantWr & smiWrRespReady) | (grantRd & smiRdRespReady);
  assign mergedEofc    = grantWr ? smiWrRespEofc : smiRdRespEofc;
  assign mergedData    = grantWr ? smiWrRespData : smiRdRespData;
  assign smiWrRespStop = ~grantWr | respBufStop;
  assign smiRdRespStop = ~grantRd | respBufStop;
  assign respXfer      = mergedReady & ~respBufStop;

  always_ff @(posedge clk) begin
    if (srst) begin
      respState   <= RespIdle;
      preferWrite <= 1'b1;
    end else if (respXfer) begin
      if (respState == RespIdle) begin
        preferWrite <= grantRd;
        if (!isFinalFlit(mergedEofc)) begin
          if (grantWr) respState <= GrantWrite;
          else         respState <= GrantRead;
        end
      end else if (isFinalFlit(mergedEofc)) begin
        respState <= RespIdle;
      end
    end
  end

  smi_frame_buffer #(.DataWidth(DataWidth)) respBuf (
    .clk(clk), .srst(srst),
    .upReady(mergedReady), .upEofc(mergedEofc), .upData(mergedData), .upStop(respBufStop),
    .downReady(smiRespReady), .downEofc(smiRespEofc), .downData(smiRespData), .downStop(smiRespStop)
  );

endmodule

// File: tb/tb_smi_frame_type_router.sv
// Self-checking bench for smi_frame_type_router: directed frame scenarios plus a
// randomized phase checked against a frame-level reference model.
module tb_smi_frame_type_router;

  localparam int DW = 128;

  typedef struct packed {
    logic [7:0]    eofc;
    logic [DW-1:0] data;
  } flit_t;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic smiReqReady = 1'b0, smiReqStop;
  logic [7:0] smiReqEofc = '0;
  logic [DW-1:0] smiReqData = '0;
  logic smiWrReqReady, smiWrReqStop = 1'b0;
  logic [7:0] smiWrReqEofc;
  logic [DW-1:0] smiWrReqData;
  logic smiRdReqReady, smiRdReqStop = 1'b0;
  logic [7:0] smiRdReqEofc;
  logic [DW-1:0] smiRdReqData;
  logic smiWrRespReady = 1'b0, smiWrRespStop;
  logic [7:0] smiWrRespEofc = '0;
  logic [DW-1:0] smiWrRespData = '0;
  logic smiRdRespReady = 1'b0, smiRdRespStop;
  logic [7:0] smiRdRespEofc = '0;
  logic [DW-1:0] smiRdRespData = '0;
  logic smiRespReady, smiRespStop = 1'b0;
  logic [7:0] smiRespEofc;
  logic [DW-1:0] smiRespData;
  logic dropError;

  always #5 clk = ~clk;

  smi_frame_type_router dut (
    .clk(clk), .srst(srst),
    .smiReqReady(smiReqReady), .smiReqEofc(smiReqEofc), .smiReqData(smiReqData), .smiReqStop(smiReqStop),
    .smiWrReqReady(smiWrReqReady), .smiWrReqEofc(smiWrReqEofc), .smiWrReqData(smiWrReqData), .smiWrReqStop(smiWrReqStop),
    .smiRdReqReady(smiRdReqReady), .smiRdReqEofc(smiRdReqEofc), .smiRdReqData(smiRdReqData), .smiRdReqStop(smiRdReqStop),
    .smiWrRespReady(smiWrRespReady), .smiWrRespEofc(smiWrRespEofc), .smiWrRespData(smiWrRespData), .smiWrRespStop(smiWrRespStop),
    .smiRdRespReady(smiRdRespReady), .smiRdRespEofc(smiRdRespEofc), .smiRdRespData(smiRdRespData), .smiRdRespStop(smiRdRespStop),
    .smiRespReady(smiRespReady), .smiRespEofc(smiRespEofc), .smiRespData(smiRespData), .smiRespStop(smiRespStop),
    .dropError(dropError)
  );

  int errCount = 0;
  int checkCount = 0;

  task automatic checkVal(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state: expected flits per destination and sticky drop flag.
  flit_t expWr[$], expRd[$], gotWr[$], gotRd[$];
  flit_t expWrResp[$], expRdResp[$], respGot[$];
  bit expDropError = 1'b0;
  bit randStops = 1'b0;
  bit wrHeld = 1'b0, respHeld = 1'b0;
  flit_t wrHeldFlit, respHeldFlit;

  always @(negedge clk) begin
    if (smiWrReqReady && !smiWrReqStop) gotWr.push_back(flit_t'({smiWrReqEofc, smiWrReqData}));
    if (smiRdReqReady && !smiRdReqStop) gotRd.push_back(flit_t'({smiRdReqEofc, smiRdReqData}));
    if (smiRespReady && !smiRespStop) respGot.push_back(flit_t'({smiRespEofc, smiRespData}));
    if (wrHeld) begin
      checkVal("wrHoldReady", smiWrReqReady, 1'b1);
      checkVal("wrHoldFlit", {smiWrReqEofc, smiWrReqData}, wrHeldFlit);
    end
    if (respHeld) begin
      checkVal("respHoldReady", smiRespReady, 1'b1);
      checkVal("respHoldFlit", {smiRespEofc, smiRespData}, respHeldFlit);
    end
    wrHeld = smiWrReqReady && smiWrReqStop && !srst;
    wrHeldFlit = flit_t'({smiWrReqEofc, smiWrReqData});
    respHeld = smiRespReady && smiRespStop && !srst;
    respHeldFlit = flit_t'({smiRespEofc, smiRespData});
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (randStops) begin
      smiWrReqStop = ($urandom_range(0, 2) == 0);
      smiRdReqStop = ($urandom_range(0, 2) == 0);
      smiRespStop  = ($urandom_range(0, 2) == 0);
    end
  end

  function automatic logic [DW-1:0] rndData();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clearAll();
    expWr.delete(); expRd.delete(); gotWr.delete(); gotRd.delete();
    expWrResp.delete(); expRdResp.delete(); respGot.delete();
  endtask

  task automatic sendFlit(input flit_t f, output int waits);
    smiReqReady = 1'b1;
    smiReqEofc  = f.eofc;
    smiReqData  = f.data;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (smiReqStop && waits < 200);
    if (smiReqStop) checkVal("reqTimeout", smiReqStop, 1'b0);
    @(posedge clk);
    #1;
    smiReqReady = 1'b0;
  endtask

  // chk: downstream is free, so every flit must move in one cycle and appear one cycle later.
  task automatic sendFrame(input logic [7:0] ftype, input int n, input logic [7:0] lastEofc, input bit chk);
    flit_t f;
    int waits;
    for (int i = 0; i < n; i++) begin
      f.data = rndData();
      if (i == 0) f.data[7:0] = ftype;
      f.eofc = (i == n - 1) ? lastEofc : 8'd0;
      if (ftype == 8'h02) expWr.push_back(f);
      else if (ftype == 8'h01) expRd.push_back(f);
      else if (i == 0) expDropError = 1'b1;
      sendFlit(f, waits);
      if (chk) begin
        checkVal("reqNoStall", waits, 1);
        checkVal("wrReady", smiWrReqReady, ftype == 8'h02);
        checkVal("rdReady", smiRdReqReady, ftype == 8'h01);
        if (ftype == 8'h02) checkVal("wrFlit", {smiWrReqEofc, smiWrReqData}, f);
        if (ftype == 8'h01) checkVal("rdFlit", {smiRdReqEofc, smiRdReqData}, f);
        checkVal("dropFlag", dropError, expDropError);
      end
    end
  endtask

  task automatic sendResp(input bit isWr, input int n);
    flit_t f;
    int waits;
    bit stopNow;
    for (int i = 0; i < n; i++) begin
      f.data = rndData();
      f.data[7:0] = isWr ? 8'hFE : 8'hFD;
      f.eofc = (i == n - 1) ? 8'($urandom_range(1, 16)) : 8'd0;
      if (isWr) begin
        expWrResp.push_back(f);
        smiWrRespReady = 1'b1; smiWrRespEofc = f.eofc; smiWrRespData = f.data;
      end else begin
        expRdResp.push_back(f);
        smiRdRespReady = 1'b1; smiRdRespEofc = f.eofc; smiRdRespData = f.data;
      end
      waits = 0;
      do begin
        @(negedge clk);
        waits++;
        stopNow = isWr ? smiWrRespStop : smiRdRespStop;
      end while (stopNow && waits < 400);
      if (stopNow) checkVal("respTimeout", stopNow, 1'b0);
      @(posedge clk);
      #1;
      if (isWr) smiWrRespReady = 1'b0;
      else      smiRdRespReady = 1'b0;
    end
  endtask

  task automatic checkReqQueues(input string tag);
    checkVal({tag, "_wrCount"}, gotWr.size(), expWr.size());
    checkVal({tag, "_rdCount"}, gotRd.size(), expRd.size());
    foreach (expWr[i]) if (i < gotWr.size()) checkVal({tag, "_wrFlit"}, gotWr[i], expWr[i]);
    foreach (expRd[i]) if (i < gotRd.size()) checkVal({tag, "_rdFlit"}, gotRd[i], expRd[i]);
    checkVal({tag, "_dropError"}, dropError, expDropError);
    expWr.delete(); expRd.delete(); gotWr.delete(); gotRd.delete();
  endtask

  // Merged output must be whole frames, each in order from one source.
  task automatic checkRespFrames(input string tag);
    bit atStart = 1'b1, fromWr = 1'b0;
    flit_t f, e;
    checkVal({tag, "_count"}, respGot.size(), expWrResp.size() + expRdResp.size());
    while (respGot.size() > 0) begin
      f = respGot.pop_front();
      if (atStart) fromWr = (expWrResp.size() > 0) && (expWrResp[0] == f);
      e = '0;
      if (fromWr && expWrResp.size() > 0) e = expWrResp.pop_front();
      else if (!fromWr && expRdResp.size() > 0) e = expRdResp.pop_front();
      checkVal(tag, f, e);
      atStart = (f.eofc != 8'd0);
    end
    expWrResp.delete(); expRdResp.delete();
  endtask

  task automatic tieTest(input string tag, input int nWr, input int nRd, input bit wrFirst);
    flit_t expOrder[$];
    flit_t g;
    fork
      sendResp(1'b1, nWr);
      sendResp(1'b0, nRd);
      begin
        @(negedge clk);
        checkVal({tag, "_stops"}, {smiWrRespStop, smiRdRespStop}, wrFirst ? 2'b01 : 2'b10);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    if (wrFirst) expOrder = {expWrResp, expRdResp};
    else         expOrder = {expRdResp, expWrResp};
    checkVal({tag, "_count"}, respGot.size(), expOrder.size());
    foreach (expOrder[i]) begin
      g = (i < respGot.size()) ? respGot[i] : flit_t'('0);
      checkVal({tag, "_order"}, g, expOrder[i]);
    end
    respGot.delete(); expWrResp.delete(); expRdResp.delete();
  endtask

  task automatic resetDut();
    srst = 1'b1;
    smiReqReady = 1'b0; smiWrRespReady = 1'b0; smiRdRespReady = 1'b0;
    @(posedge clk);
    #1;
    checkVal("rstWrReady", smiWrReqReady, 1'b0);
    checkVal("rstRdReady", smiRdReqReady, 1'b0);
    checkVal("rstRespReady", smiRespReady, 1'b0);
    checkVal("rstDropError", dropError, 1'b0);
    checkVal("rstStops", {smiReqStop, smiWrRespStop, smiRdRespStop}, 3'b111);
    srst = 1'b0;
    expDropError = 1'b0;
    @(posedge clk);
    #1;
    clearAll();
  endtask

  initial begin
    flit_t f;
    int waits;
    repeat (2) @(posedge clk);
    #1;
    resetDut();

    // 3-flit write frame, then single-flit read followed directly by a write
    sendFrame(8'h02, 3, 8'd16, 1'b1);
    sendFrame(8'h01, 1, 8'd4, 1'b1);
    sendFrame(8'h02, 2, 8'd7, 1'b1);
    // unknown type is swallowed at full rate and latches dropError
    sendFrame(8'h7A, 2, 8'd9, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkReqQueues("directed");

    // downstream stall mid-frame
    fork
      sendFrame(8'h02, 6, 8'd12, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        smiWrReqStop = 1'b1;
        repeat (5) begin
          @(negedge clk);
          checkVal("stallReqStop", smiReqStop, 1'b1);
        end
        @(posedge clk);
        #1;
        smiWrReqStop = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    checkReqQueues("stall");

    // response arbitration: first tie to write, then alternation
    resetDut();
    tieTest("tieAfterReset", 2, 2, 1'b1);
    sendResp(1'b1, 1);
    repeat (3) @(posedge clk);
    #1;
    checkRespFrames("wrAlone");
    tieTest("tieAfterWrite", 1, 1, 1'b0);

    // reset during the second flit of a 4-flit write frame
    f.data = rndData();
    f.data[7:0] = 8'h02;
    f.eofc = 8'd0;
    sendFlit(f, waits);
    smiReqReady = 1'b1;
    smiReqEofc = 8'd0;
    smiReqData = rndData();
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    smiReqReady = 1'b0;
    checkVal("midRstReadys", {smiWrReqReady, smiRdReqReady, smiRespReady}, 3'b000);
    clearAll();
    expDropError = 1'b0;
    sendFrame(8'h01, 2, 8'd3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkReqQueues("afterMidRst");

    // randomized traffic on both paths at once with random downstream stalls
    randStops = 1'b1;
    fork
      for (int n = 0; n < 40; n++) begin
        int r;
        logic [7:0] t;
        r = $urandom_range(0, 3);
        t = (r < 2) ? 8'h02 : (r == 2) ? 8'h01 : 8'(8'h10 + $urandom_range(0, 200));
        sendFrame(t, $urandom_range(1, 4), 8'($urandom_range(1, 16)), 1'b0);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      for (int n = 0; n < 15; n++) begin
        sendResp(1'b1, $urandom_range(1, 4));
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      for (int n = 0; n < 15; n++) begin
        sendResp(1'b0, $urandom_range(1, 4));
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    join
    randStops = 1'b0;
    @(posedge clk);
    #1;
    smiWrReqStop = 1'b0; smiRdReqStop = 1'b0; smiRespStop = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkReqQueues("random");
    checkRespFrames("randomResp");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
